core_wb_stage: RTL and testbench

CORE_WB_STAGE -- requirements
Module: core_wb_stage

---
 rtl/core_pkg.sv | 26 ++
 rtl/core_load_align.sv | 27 ++
 rtl/core_wb_stage.sv | 150 +++++++++++++++
 tb/tb_core_wb_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core pipeline: write-back source and load size encodings.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_src_e;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4
    } mem_size_e;

    // Link address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/core_load_align.sv
// Combinational load lane select and sign/zero extension; alignment is not checked.
module core_load_align
    import core_pkg::*;
(
    input  mem_size_e        size,
    input  logic [1:0]       addr_lo,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        data_c = rdata;
        case (size)
            LB:      data_c = {{(XLEN-8){byte_v[7]}}, byte_v};
            LBU:     data_c = {{(XLEN-8){1'b0}}, byte_v};
            LH:      data_c = {{(XLEN-16){half_v[15]}}, half_v};
            LHU:     data_c = {{(XLEN-16){1'b0}}, half_v};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/core_wb_stage.sv
// Write-back stage: selects the result, waits for load data, drives the RF write port.
// Optional bypass outputs enabled by defining CORE_WB_FWD_EN.
module core_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  wb_src_e              ex_wb_src,
    input  logic [RF_ADDR_W-1:0] ex_rd,
    input  logic                 ex_rd_we,
    input  logic [XLEN-1:0]      ex_alu_res,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_csr_rdata,
    input  mem_size_e            ex_mem_size,
    input  logic [1:0]           ex_addr_lo,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_err,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_fault,
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 fwd_pend
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [RF_ADDR_W-1:0]   ld_rd_q;
    logic                   ld_we_q;
    mem_size_e              ld_size_q;
    logic [1:0]             ld_lo_q;
    logic                   ld_latch;

    logic                   rf_we_d;
    logic [RF_ADDR_W-1:0]   rf_waddr_d;
    logic [XLEN-1:0]        rf_wdata_d;
    logic                   wb_fault_d;
    logic [XLEN-1:0]        ex_result_c;
    logic [XLEN-1:0]        load_data_c;

    assign ex_ready = (state_q == IDLE);

    core_load_align u_load_align (
        .size    (ld_size_q),
        .addr_lo (ld_lo_q),
        .rdata   (mem_rdata),
        .data_c  (load_data_c)
    );

    // Non-load result mux.
    always_comb begin
        ex_result_c = ex_alu_res;
        case (ex_wb_src)
            WB_PC4:  ex_result_c = pc_plus4(ex_pc);
            WB_CSR:  ex_result_c = ex_csr_rdata;
            default: ex_result_c = ex_alu_res;
        endcase
    end

    // Next state and next register-file write.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        wb_fault_d = 1'b0;
        ld_latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_wb_src == WB_MEM) begin
                        state_d  = WAIT_MEM;
                        ld_latch = 1'b1;
                    end else begin
                        rf_we_d    = ex_rd_we && (ex_rd != '0);
                        rf_waddr_d = ex_rd;
                        rf_wdata_d = ex_result_c;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (mem_err) begin
                        wb_fault_d = 1'b1;
                    end else begin
                        rf_we_d    = ld_we_q && (ld_rd_q != '0);
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = load_data_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wb_fault  <= 1'b0;
            ld_rd_q   <= '0;
            ld_we_q   <= 1'b0;
            ld_size_q <= LB;
            ld_lo_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            wb_fault <= wb_fault_d;
            if (ld_latch) begin
                ld_rd_q   <= ex_rd;
                ld_we_q   <= ex_rd_we;
                ld_size_q <= ex_mem_size;
                ld_lo_q   <= ex_addr_lo;
            end
        end
    end

`ifdef CORE_WB_FWD_EN
    logic pend_c;

    // While a load is outstanding, advertise its destination so exec can stall on it.
    assign pend_c    = (state_q == WAIT_MEM) && ld_we_q && (ld_rd_q != '0);
    assign fwd_pend  = pend_c;
    assign fwd_valid = rf_we;
    assign fwd_rd    = pend_c ? ld_rd_q : rf_waddr;
    assign fwd_data  = rf_wdata;
`else
    assign fwd_pend  = 1'b0;
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_core_wb_stage.sv
// Bench for core_wb_stage: directed vectors, per-cycle model compare, literal pins.
module tb_core_wb_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    wb_src_e     ex_wb_src;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] ex_alu_res, ex_pc, ex_csr_rdata;
    mem_size_e   ex_mem_size;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        rf_we, wb_fault, fwd_valid, fwd_pend;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    core_wb_stage #(.RF_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wb_src(ex_wb_src), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_alu_res(ex_alu_res), .ex_pc(ex_pc), .ex_csr_rdata(ex_csr_rdata),
        .ex_mem_size(ex_mem_size), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_fault(wb_fault),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pend(fwd_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load extraction using shifts, masks and two's-complement wrap.
    function automatic logic [31:0] m_extract(input mem_size_e sz, input logic [1:0] lo,
                                              input logic [31:0] d);
        logic [31:0] v;
        case (sz)
            LB:  begin v = (d >> (8 * lo)) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            LBU: v = (d >> (8 * lo)) & 32'hFF;
            LH:  begin v = (d >> (16 * lo[1])) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            LHU: v = (d >> (16 * lo[1])) & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    // Transaction-level model: one pending load slot plus the expected RF write.
    logic        m_pend = 1'b0;
    logic [4:0]  m_rd = '0;
    logic        m_we = 1'b0;
    mem_size_e   m_sz = LB;
    logic [1:0]  m_lo = '0;
    logic        e_we = 1'b0, e_fault = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0; e_we = 1'b0; e_fault = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            e_we = 1'b0;
            e_fault = 1'b0;
            if (m_pend) begin
                if (mem_rvalid) begin
                    m_pend = 1'b0;
                    if (mem_err) e_fault = 1'b1;
                    else begin
                        e_addr = m_rd;
                        e_data = m_extract(m_sz, m_lo, mem_rdata);
                        e_we   = m_we && (m_rd != 0);
                    end
                end
            end else if (ex_valid) begin
                if (ex_wb_src == WB_MEM) begin
                    m_pend = 1'b1; m_rd = ex_rd; m_we = ex_rd_we; m_sz = ex_mem_size; m_lo = ex_addr_lo;
                end else begin
                    e_addr = ex_rd;
                    e_we   = ex_rd_we && (ex_rd != 0);
                    if (ex_wb_src == WB_PC4)      e_data = ex_pc + 32'd4;
                    else if (ex_wb_src == WB_CSR) e_data = ex_csr_rdata;
                    else                          e_data = ex_alu_res;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        logic pend_x;
        pend_x = m_pend && m_we && (m_rd != 0);
        chk("cyc_ex_ready", 32'(ex_ready), 32'(!m_pend));
        chk("cyc_rf_we",    32'(rf_we),    32'(e_we));
        chk("cyc_rf_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("cyc_rf_wdata", rf_wdata,      e_data);
        chk("cyc_wb_fault", 32'(wb_fault), 32'(e_fault));
`ifdef CORE_WB_FWD_EN
        chk("cyc_fwd_valid", 32'(fwd_valid), 32'(e_we));
        chk("cyc_fwd_pend",  32'(fwd_pend),  32'(pend_x));
        chk("cyc_fwd_rd",    32'(fwd_rd),    32'(pend_x ? m_rd : e_addr));
        chk("cyc_fwd_data",  fwd_data,       e_data);
`else
        chk("cyc_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("cyc_fwd_pend",  32'(fwd_pend),  32'd0);
        chk("cyc_fwd_rd",    32'(fwd_rd),    32'd0);
        chk("cyc_fwd_data",  fwd_data,       32'd0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input wb_src_e src, input logic [4:0] rd, input logic we,
                         input logic [31:0] val);
        ex_valid = 1'b1; ex_wb_src = src; ex_rd = rd; ex_rd_we = we;
        ex_alu_res   = (src == WB_ALU) ? val : 32'hA5A5_0001;
        ex_pc        = (src == WB_PC4) ? val : 32'h0000_1000;
        ex_csr_rdata = (src == WB_CSR) ? val : 32'h5A5A_0002;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
    endtask

    task automatic issue_load(input mem_size_e sz, input logic [4:0] rd, input logic [1:0] lo);
        issue(WB_MEM, rd, 1'b1, 32'h0);
        ex_mem_size = sz; ex_addr_lo = lo;
    endtask

    // Full load: accept, one idle wait cycle, response, then pin the written value.
    task automatic do_load(input string name, input mem_size_e sz, input logic [4:0] rd,
                           input logic [1:0] lo, input logic [31:0] d, input logic [31:0] exp);
        issue_load(sz, rd, lo);
        tick();
        idle_ex();
        chk({name, "_stall"}, 32'(ex_ready), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = d;
        tick();
        mem_rvalid = 1'b0;
        chk({name, "_we"},   32'(rf_we),    32'd1);
        chk({name, "_addr"}, 32'(rf_waddr), 32'(rd));
        chk({name, "_data"}, rf_wdata,      exp);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_wb_src = WB_ALU; ex_rd = '0; ex_rd_we = 1'b0;
        ex_alu_res = '0; ex_pc = '0; ex_csr_rdata = '0; ex_mem_size = LB; ex_addr_lo = '0;
        mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_fwd_pend", 32'(fwd_pend), 32'd0);
        rst_n = 1'b1;
        tick();

        issue(WB_ALU, 5'd5, 1'b1, 32'h0000_1234);
        tick();
        idle_ex();
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_addr", 32'(rf_waddr), 32'd5);
        chk("alu_data", rf_wdata, 32'h0000_1234);
        tick();
        chk("alu_we_once", 32'(rf_we), 32'd0);

        issue(WB_PC4, 5'd1, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("pc4_wrap", rf_wdata, 32'h0000_0000);
        issue(WB_CSR, 5'd3, 1'b1, 32'hCAFE_BABE);
        tick();
        chk("b2b_csr", rf_wdata, 32'hCAFE_BABE);
        issue(WB_ALU, 5'd4, 1'b1, 32'h0000_0055);
        tick();
        chk("b2b_alu_we", 32'(rf_we), 32'd1);
        chk("b2b_alu_data", rf_wdata, 32'h0000_0055);

        issue(WB_ALU, 5'd0, 1'b1, 32'h0000_DEAD);
        tick();
        chk("rd0_we", 32'(rf_we), 32'd0);
        chk("rd0_data", rf_wdata, 32'h0000_DEAD);
        issue(WB_ALU, 5'd6, 1'b0, 32'h0000_BEEF);
        tick();
        idle_ex();
        chk("nowe_we", 32'(rf_we), 32'd0);
        chk("nowe_addr", 32'(rf_waddr), 32'd6);

        mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0; mem_err = 1'b0;
        chk("idle_rvalid_fault", 32'(wb_fault), 32'd0);
        chk("idle_rvalid_we", 32'(rf_we), 32'd0);

        // LB with exec holding a result across the stall, accepted when the load writes.
        issue_load(LB, 5'd7, 2'd3);
        tick();
        issue(WB_ALU, 5'd12, 1'b1, 32'h0000_0077);
        chk("lb_stall", 32'(ex_ready), 32'd0);
        tick();
        chk("lb_stall2", 32'(ex_ready), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        chk("lb_ready", 32'(ex_ready), 32'd1);
        tick();
        idle_ex();
        chk("after_ld_we", 32'(rf_we), 32'd1);
        chk("after_ld_data", rf_wdata, 32'h0000_0077);

        do_load("lhu", LHU, 5'd8,  2'd2, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lh",  LH,  5'd13, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu", LBU, 5'd14, 2'd1, 32'h0000_F100, 32'h0000_00F1);

        issue_load(LW, 5'd9, 2'd1);
        tick();
        idle_ex();
`ifdef CORE_WB_FWD_EN
        chk("pend_flag", 32'(fwd_pend), 32'd1);
        chk("pend_rd", 32'(fwd_rd), 32'd9);
`else
        chk("pend_flag", 32'(fwd_pend), 32'd0);
        chk("pend_rd", 32'(fwd_rd), 32'd0);
`endif
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("lw_data", rf_wdata, 32'h1234_5678);

        issue_load(LW, 5'd10, 2'd0);
        tick();
        idle_ex();
        mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0; mem_err = 1'b0;
        chk("err_we", 32'(rf_we), 32'd0);
        chk("err_fault", 32'(wb_fault), 32'd1);
        chk("err_ready", 32'(ex_ready), 32'd1);
        tick();
        chk("err_fault_once", 32'(wb_fault), 32'd0);

        issue_load(LW, 5'd11, 2'd0);
        tick();
        idle_ex();
        chk("rstw_stall", 32'(ex_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rstw_we", 32'(rf_we), 32'd0);
        chk("rstw_fault", 32'(wb_fault), 32'd0);
        chk("rstw_ready", 32'(ex_ready), 32'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
